// File: rtl/aes_key_loader.sv
// aes_key_loader: streams groups of 8 RAM words into 128-bit keys handed to the AES core via valid/ready.
// Define AES_KEY_LOADER_BYTESWAP_EN to byte-swap each captured word for big-endian key images.
module aes_key_loader #(
    parameter int                ADDR_W    = 20,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 20'h78000,
    parameter int                NUM_KEYS  = 16,
    parameter int                WORDS     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic [127:0]      key_out,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              busy,
    output logic              done,
    output logic [15:0]       key_idx
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_HOLD, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        cnt_q, cnt_d, cap_q, cap_d;
    logic [15:0]       idx_q, idx_d;
    logic [127:0]      key_q, key_d;
    logic              valid_q, valid_d, done_q, done_d, rd_q, rd_d;
    logic [15:0]       word;

`ifdef AES_KEY_LOADER_BYTESWAP_EN
    assign word = {mem_rdata[7:0], mem_rdata[15:8]};
`else
    assign word = mem_rdata;
`endif

    assign mem_rd    = state_q == S_FETCH;
    assign mem_addr  = addr_q;
    assign key_out   = key_q;
    assign key_valid = valid_q;
    assign busy      = state_q == S_FETCH || state_q == S_DRAIN || state_q == S_HOLD;
    assign done      = done_q;
    assign key_idx   = idx_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        idx_d   = idx_q;
        key_d   = key_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        rd_d    = state_q == S_FETCH;
        // Read data lands one cycle after its strobe; rd_q marks that return slot.
        if (rd_q) begin
            key_d[{cap_q, 4'b0} +: 16] = word;
            cap_d = cap_q + 3'd1;
        end
        case (state_q)
            S_IDLE, S_DONE: if (start) begin
                state_d = S_FETCH;
                addr_d  = BASE_ADDR;
                idx_d   = '0;
                cnt_d   = '0;
                cap_d   = '0;
            end
            S_FETCH: begin
                addr_d  = addr_q + 1'b1;
                cnt_d   = cnt_q + 3'd1;
                state_d = cnt_q == 3'(WORDS - 1) ? S_DRAIN : S_FETCH;
            end
            S_DRAIN: begin
                state_d = S_HOLD;
                valid_d = 1'b1;
            end
            S_HOLD: if (key_ready) begin
                valid_d = 1'b0;
                if (idx_q == 16'(NUM_KEYS - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_FETCH;
                    idx_d   = idx_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= BASE_ADDR;
            cnt_q   <= '0;
            cap_q   <= '0;
            idx_q   <= '0;
            key_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            idx_q   <= idx_d;
            key_q   <= key_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
        end
    end
endmodule

// File: tb/tb_aes_key_loader.sv
// tb_aes_key_loader: directed checks of address sequencing, key assembly, handshake, wrap and reset.
module tb_aes_key_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    localparam logic [127:0] K0 = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
    localparam logic [127:0] K1 = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;
`ifdef AES_KEY_LOADER_BYTESWAP_EN
    localparam logic [127:0] KW = 128'hB4A3_B3A2_B2A1_B1A0_B0AF_BFAE_BEAD_BDAC;
`else
    localparam logic [127:0] KW = 128'hA3B4_A2B3_A1B2_A0B1_AFB0_AEBF_ADBE_ACBD;
`endif

    logic         start0 = 0, start1 = 0, start2 = 0;
    logic         rdy0 = 0, rdy1 = 0, rdy2 = 0;
    logic         rd0, rd1, rd2, v0, v1, v2, b0, b1, b2, d0, d1, d2;
    logic [19:0]  a0, a1, a2;
    logic [15:0]  rdata0, rdata1, rdata2, i0, i1, i2;
    logic [127:0] k0, k1, k2;

    int errs = 0;
    int checks = 0;

    function automatic logic [15:0] ram(input logic [19:0] a);
        return a[19:16] == 4'h7 ? {4{a[3:0]}} : {4'hA, a[3:0], 4'hB, a[3:0] + 4'h1};
    endfunction

    always @(posedge clk) begin
        if (rd0) rdata0 <= ram(a0);
        if (rd1) rdata1 <= ram(a1);
        if (rd2) rdata2 <= ram(a2);
    end

    aes_key_loader u0 (.clk(clk), .rst(rst), .start(start0), .mem_rd(rd0), .mem_addr(a0),
        .mem_rdata(rdata0), .key_out(k0), .key_valid(v0), .key_ready(rdy0), .busy(b0),
        .done(d0), .key_idx(i0));
    aes_key_loader #(.NUM_KEYS(3)) u1 (.clk(clk), .rst(rst), .start(start1), .mem_rd(rd1),
        .mem_addr(a1), .mem_rdata(rdata1), .key_out(k1), .key_valid(v1), .key_ready(rdy1),
        .busy(b1), .done(d1), .key_idx(i1));
    aes_key_loader #(.BASE_ADDR(20'hFFFFC), .NUM_KEYS(2)) u2 (.clk(clk), .rst(rst),
        .start(start2), .mem_rd(rd2), .mem_addr(a2), .mem_rdata(rdata2), .key_out(k2),
        .key_valid(v2), .key_ready(rdy2), .busy(b2), .done(d2), .key_idx(i2));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int          vn, dn, dat;
    int          vat[3];
    logic [15:0] vidx[3];
    logic [127:0] vkey[3];
    logic [19:0] ea;

    initial begin
        #2 rst = 1'b0;
        #1;
        chk("rst_addr", 128'(a0), 128'h78000);
        chk("rst_addr_wrap", 128'(a2), 128'hFFFFC);
        chk("rst_flags", 128'({rd0, v0, b0, d0}), 128'h0);
        chk("rst_key", k0, 128'h0);
        chk("rst_idx", 128'(i0), 128'h0);
        @(posedge clk); #1 rst = 1'b1;
        tick;

        // single key: addresses, latency, assembly
        start0 = 1; tick; start0 = 0;
        for (int k = 0; k < 8; k++) begin
            chk("f0_rd", 128'({rd0, b0}), 128'b11);
            chk("f0_addr", 128'(a0), 128'(20'h78000 + k));
            tick;
        end
        chk("f0_drain", 128'({rd0, v0}), 128'b00);
        tick;
        chk("f0_valid", 128'({v0, b0}), 128'b11);
        chk("f0_key", k0, K0);
        chk("f0_idx", 128'(i0), 128'h0);

        // backpressure
        for (int c = 0; c < 20; c++) begin
            tick;
            chk("bp_key", k0, K0);
            chk("bp_flags", 128'({rd0, v0}), 128'b01);
        end
        rdy0 = 1; tick; rdy0 = 0;
        chk("acc_state", 128'({rd0, v0}), 128'b10);
        chk("acc_idx", 128'(i0), 128'h1);
        for (int k = 0; k < 8; k++) begin
            chk("f1_addr", 128'(a0), 128'(20'h78008 + k));
            tick;
        end
        tick;
        chk("f1_valid", 128'(v0), 128'h1);
        chk("f1_key", k0, K1);

        // three keys back to back, start ignored while busy
        vn = 0; dn = 0; dat = 0;
        rdy1 = 1;
        start1 = 1; tick; start1 = 0;
        for (int c = 1; c <= 40; c++) begin
            if (v1) begin
                if (vn < 3) begin
                    vat[vn] = c; vidx[vn] = i1; vkey[vn] = k1;
                end
                vn++;
            end
            if (d1) begin dn++; dat = c; end
            start1 = (c == 5);
            tick;
        end
        start1 = 0;
        chk("mk_vcount", 128'(vn), 128'd3);
        chk("mk_vat0", 128'(vat[0]), 128'd10);
        chk("mk_vat1", 128'(vat[1]), 128'd20);
        chk("mk_vat2", 128'(vat[2]), 128'd30);
        chk("mk_idx0", 128'(vidx[0]), 128'd0);
        chk("mk_idx1", 128'(vidx[1]), 128'd1);
        chk("mk_idx2", 128'(vidx[2]), 128'd2);
        chk("mk_key1", vkey[1], K1);
        chk("mk_key2", vkey[2], K0);
        chk("mk_dcount", 128'(dn), 128'd1);
        chk("mk_dat", 128'(dat), 128'd31);
        chk("mk_idle", 128'({b1, rd1}), 128'b00);
        start1 = 1; tick; start1 = 0;
        chk("mk_restart", 128'({rd1, b1}), 128'b11);
        chk("mk_restart_addr", 128'(a1), 128'h78000);
        chk("mk_restart_idx", 128'(i1), 128'h0);

        // address wrap, then reset in the middle of a fetch
        start2 = 1; tick; start2 = 0;
        for (int k = 0; k < 8; k++) begin
            ea = 20'hFFFFC + 20'(k);
            chk("wr_addr", 128'(a2), 128'(ea));
            tick;
        end
        tick;
        chk("wr_valid", 128'(v2), 128'h1);
        chk("wr_key", k2, KW);
        rdy2 = 1; tick; rdy2 = 0;
        repeat (4) tick;
        chk("mid_fetch", 128'({rd2, a2}), 128'({1'b1, 20'h00008}));
        #3 rst = 1'b0;
        #1;
        chk("mr_flags", 128'({rd2, v2, b2, d2}), 128'h0);
        chk("mr_addr", 128'(a2), 128'hFFFFC);
        chk("mr_key", k2, 128'h0);
        chk("mr_idx", 128'(i2), 128'h0);
        @(posedge clk); #1 rst = 1'b1;
        vn = 0;
        for (int c = 0; c < 12; c++) begin
            if (v2 || rd2) vn++;
            tick;
        end
        chk("mr_quiet", 128'(vn), 128'd0);
        start2 = 1; tick; start2 = 0;
        chk("rs_addr", 128'({rd2, a2}), 128'({1'b1, 20'hFFFFC}));
        repeat (9) tick;
        chk("rs_valid", 128'(v2), 128'h1);
        chk("rs_key", k2, KW);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
